instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Writer side of the instruction-memory interface: accepts one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) per handshake.
- Serialises it into the byte stream that the fetch stage later parses, writing one byte per cycle into instruction memory.
- Used by the testbench/program loader to build programs in instr_mem without hand-coding bytes.
- Sits between the program source and the instruction-memory write port.

Parameters:
- ADDR_W, 64: width of the byte address and write-pointer counter.
- RESET_ADDR, 0: value of the write pointer after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_load  in  1  load write pointer from addr_in; honoured only in IDLE.
- addr_in  in  ADDR_W  new write-pointer value.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction (high only in IDLE).
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  source register specifier.
- rB  in  4  destination register specifier.
- valC  in  64  constant, displacement or destination.
- mem_we  out  1  byte write strobe.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  8  byte being written.
- done  out  1  one-cycle pulse on the last byte of an instruction.
- err  out  1  one-cycle pulse when an instruction is rejected.
- wr_ptr  out  ADDR_W  address where the next instruction will start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wr_ptr=RESET_ADDR, in_ready=1; mem_we, done and err all 0; mem_addr=0, mem_wdata=0. Reset asserted mid-EMIT aborts the instruction; bytes already written stay in memory.
- States:
  - IDLE: in_ready=1.
  - EMIT: in_ready=0, byte index idx counts 0..len-1.
- Handshake: accept when in_valid && in_ready on a clock edge. All fields are captured into registers and inputs are ignored afterwards.
- Length by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes.
  - 7 (jXX), 8 (call): 9 bytes.
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes.
- Byte layout:
  - byte0 = {icode, ifun}.
  - byte1 = {rA, rB}, only for 2-, 3-, 4-, 5-, 6-, A- and B-type instructions.
  - Then valC, little-endian (LS byte first). For 7 and 8 valC starts at byte1; for 3, 4 and 5 it starts at byte2.
- Forced specifiers: irmovq forces rA=F; pushq and popq force rB=F, regardless of the inputs.
- Timing: on acceptance at edge N, the FSM enters EMIT. Byte k is driven with mem_we=1 during cycle N+1+k, at mem_addr=wr_ptr+k.
- Pointer update: wr_ptr increments by 1 per written byte and wraps modulo 2^ADDR_W. mem_addr equals the current wr_ptr while mem_we=1.
- End of instruction: the last byte asserts done in the same cycle, and the FSM returns to IDLE at the next edge. Back-to-back instructions therefore take len+1 cycles each.
- Invalid icode (C..F): accepted, no memory write, err pulses for one cycle at N+1, wr_ptr unchanged, FSM stays in IDLE.
- addr_load:
  - In IDLE, wr_ptr <= addr_in.
  - If addr_load and an accept happen on the same edge, the instruction starts at addr_in.
  - In EMIT, addr_load is ignored.
- Outputs are registered. mem_wdata and mem_addr hold their last values when mem_we=0.

Optional Feature:
- Macro: INSTR_ENCODER_FUNC_CHECK_EN.
- Defined: additionally reject, as with an invalid icode (err pulse, no write), any of:
  - ifun>6 for icode 2 or 7;
  - ifun>3 for icode 6;
  - ifun!=0 for any other icode;
  - rA=F for icode 2, 4, 5, 6, A or B;
  - rB=F for icode 2, 4, 5 or 6.
- Undefined: ifun, rA and rB are written unchecked. Only icode C..F is rejected.

Test Plan:
- Reset, addr_load addr_in=0x100, then irmovq (icode=3, ifun=0, rB=2, rA=5, valC=0x0123456789ABCDEF) -> bytes 30 F2 EF CD AB 89 67 45 23 01 at 0x100..0x109 on 10 consecutive cycles; done on 0x109; wr_ptr=0x10A.
- Back-to-back nop, halt, ret with in_valid held high -> bytes 10, 00, 90 at consecutive addresses; in_ready low one cycle after each accept; 2 cycles per instruction.
- call valC=0x40 at 0x0 followed by pushq rA=3 -> 80 40 00 00 00 00 00 00 00 at 0x0..0x8, then A0 3F at 0x9..0xA.
- icode=0xC -> err=1 for one cycle, mem_we never asserted, wr_ptr unchanged. With the macro defined, OPq with ifun=5 -> err, no write.
- ADDR_W=8, wr_ptr=0xFE, OPq rA=1, rB=2, ifun=0 -> 60 at 0xFE, 12 at 0xFF; wr_ptr wraps to 0x00.
- rst_n low after 3 bytes of rmmovq -> outputs drop to reset values immediately; wr_ptr=RESET_ADDR; in_ready=1 after release; addr_load pulsed during EMIT has no effect.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Serialises one decoded Y86-64 instruction per handshake into
//               its byte encoding, one instruction-memory write per cycle.
//               Optional macro INSTR_ENCODER_FUNC_CHECK_EN adds ifun/register
//               legality checks on top of the icode check.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_ptr
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        len_q, len_d;
    logic [79:0]       buf_q, buf_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [3:0]        w_len;
    logic [79:0]       w_bytes;
    logic              w_bad;
    logic [ADDR_W-1:0] w_start;
    logic [3:0]        w_next_idx;

    // Decode the presented fields into a full little-endian byte image.
    always_comb begin
        w_ra = rA;
        w_rb = rB;
        if (icode == 4'h3) begin
            w_ra = 4'hF;
        end
        if ((icode == 4'hA) || (icode == 4'hB)) begin
            w_rb = 4'hF;
        end
        w_b0  = {icode, ifun};
        w_b1  = {w_ra, w_rb};
        w_bad = 1'b0;
        case (icode)
            4'h0, 4'h1, 4'h9: begin
                w_len   = 4'd1;
                w_bytes = {72'h0, w_b0};
            end
            4'h2, 4'h6, 4'hA, 4'hB: begin
                w_len   = 4'd2;
                w_bytes = {64'h0, w_b1, w_b0};
            end
            4'h7, 4'h8: begin
                w_len   = 4'd9;
                w_bytes = {8'h0, valC, w_b0};
            end
            4'h3, 4'h4, 4'h5: begin
                w_len   = 4'd10;
                w_bytes = {valC, w_b1, w_b0};
            end
            default: begin
                w_len   = 4'd1;
                w_bytes = '0;
                w_bad   = 1'b1;
            end
        endcase
`ifdef INSTR_ENCODER_FUNC_CHECK_EN
        case (icode)
            4'h2, 4'h7: if (ifun > 4'h6)  w_bad = 1'b1;
            4'h6:       if (ifun > 4'h3)  w_bad = 1'b1;
            default:    if (ifun != 4'h0) w_bad = 1'b1;
        endcase
        if ((icode inside {4'h2, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) && (rA == 4'hF)) begin
            w_bad = 1'b1;
        end
        if ((icode inside {4'h2, 4'h4, 4'h5, 4'h6}) && (rB == 4'hF)) begin
            w_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        idx_d       = idx_q;
        len_d       = len_q;
        buf_d       = buf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_start     = addr_load ? addr_in : wr_ptr_q;
        w_next_idx  = idx_q + 4'd1;
        case (state_q)
            S_IDLE: begin
                if (addr_load) begin
                    wr_ptr_d = addr_in;
                end
                if (in_valid) begin
                    if (w_bad) begin
                        err_d = 1'b1;
                    end else begin
                        // Byte 0 is registered on the accept edge itself.
                        state_d     = S_EMIT;
                        idx_d       = 4'd0;
                        len_d       = w_len;
                        buf_d       = w_bytes;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = w_start;
                        mem_wdata_d = w_bytes[7:0];
                        done_d      = (w_len == 4'd1);
                    end
                end
            end
            S_EMIT: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (w_next_idx == len_q) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d       = w_next_idx;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q + ADDR_W'(1);
                    mem_wdata_d = buf_q[{w_next_idx, 3'b000} +: 8];
                    done_d      = ((w_next_idx + 4'd1) == len_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= RESET_ADDR;
            mem_addr_q  <= '0;
            idx_q       <= 4'd0;
            len_q       <= 4'd0;
            buf_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            buf_q       <= buf_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wr_ptr    = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder: directed cases plus
//               randomized instructions against a rule-based byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        addr_load;
    logic [63:0] addr_in;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        done;
    logic        err;
    logic [63:0] wr_ptr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_ptr;
    logic [7:0]  exp_bytes[$];

    instr_encoder #(.ADDR_W(64), .RESET_ADDR(64'h0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .rA        (rA),
        .rB        (rB),
        .valC      (valC),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .wr_ptr    (wr_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Builds the expected byte list straight from the instruction format rules.
    task automatic ref_encode(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] vc, output bit bad);
        bit has_regs;
        bit has_c;
        bad = (ic >= 4'hC);
`ifdef INSTR_ENCODER_FUNC_CHECK_EN
        if ((ic == 4'h2 || ic == 4'h7) && fn > 4'h6) bad = 1;
        else if (ic == 4'h6 && fn > 4'h3) bad = 1;
        else if (!(ic == 4'h2 || ic == 4'h7 || ic == 4'h6) && fn != 4'h0) bad = 1;
        if ((ic inside {4'h2, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) && ra == 4'hF) bad = 1;
        if ((ic inside {4'h2, 4'h4, 4'h5, 4'h6}) && rb == 4'hF) bad = 1;
`endif
        has_regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        has_c    = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        if (ic == 4'h3) ra = 4'hF;
        if (ic == 4'hA || ic == 4'hB) rb = 4'hF;
        exp_bytes.delete();
        exp_bytes.push_back({ic, fn});
        if (has_regs) exp_bytes.push_back({ra, rb});
        if (has_c) begin
            for (int i = 0; i < 8; i++) begin
                logic [63:0] sh;
                sh = vc >> (8 * i);
                exp_bytes.push_back(sh[7:0]);
            end
        end
    endtask

    task automatic scramble_inputs();
        icode     = 4'($urandom);
        ifun      = 4'($urandom);
        rA        = 4'($urandom);
        rB        = 4'($urandom);
        valC      = {$urandom, $urandom};
        addr_load = 1'($urandom);
        addr_in   = {$urandom, $urandom};
    endtask

    // Called and returns just after a falling edge with the encoder idle.
    task automatic do_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] vc, input bit ld,
                            input logic [63:0] la, input int abort_at);
        logic [63:0] start;
        bit          bad;
        int          n;
        ref_encode(ic, fn, ra, rb, vc, bad);
        n     = exp_bytes.size();
        start = ld ? la : exp_ptr;
        check_eq("in_ready_idle", in_ready, 1);
        icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
        in_valid = 1'b1; addr_load = ld; addr_in = la;
        @(posedge clk);
        @(negedge clk);
        if (bad) begin
            check_eq("err_pulse", err, 1);
            check_eq("err_no_write", mem_we, 0);
            check_eq("err_ready", in_ready, 1);
            check_eq("err_wr_ptr", wr_ptr, start);
            exp_ptr  = start;
            in_valid = 1'b0; addr_load = 1'b0;
            @(negedge clk);
            check_eq("err_one_cycle", err, 0);
            check_eq("err_no_write2", mem_we, 0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("byte_we", mem_we, 1);
            check_eq("byte_addr", mem_addr, start + 64'(k));
            check_eq("byte_data", mem_wdata, exp_bytes[k]);
            check_eq("byte_done", done, (k == n - 1));
            check_eq("byte_ready", in_ready, 0);
            check_eq("byte_ptr", wr_ptr, start + 64'(k));
            check_eq("byte_err", err, 0);
            scramble_inputs();
            if (abort_at == k + 1) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_we", mem_we, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_addr", mem_addr, 0);
                check_eq("rst_wdata", mem_wdata, 0);
                check_eq("rst_ptr", wr_ptr, 0);
                check_eq("rst_ready", in_ready, 1);
                in_valid = 1'b0; addr_load = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                exp_ptr = 64'h0;
                @(negedge clk);
                check_eq("rst_rel_ready", in_ready, 1);
                check_eq("rst_rel_ptr", wr_ptr, 0);
                check_eq("rst_rel_we", mem_we, 0);
                return;
            end
        end
        exp_ptr = start + 64'(n);
        @(negedge clk);
        check_eq("end_we", mem_we, 0);
        check_eq("end_done", done, 0);
        check_eq("end_ptr", wr_ptr, exp_ptr);
        check_eq("end_ready", in_ready, 1);
        in_valid = 1'b0; addr_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_in = '0;
        icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
        exp_ptr = 64'h0;
        #1;
        check_eq("reset_ready", in_ready, 1);
        check_eq("reset_we", mem_we, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_err", err, 0);
        check_eq("reset_ptr", wr_ptr, 0);
        check_eq("reset_addr", mem_addr, 0);
        check_eq("reset_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Pointer load on its own, then irmovq at 0x100.
        addr_load = 1'b1; addr_in = 64'h100;
        @(negedge clk);
        addr_load = 1'b0;
        check_eq("load_ptr", wr_ptr, 64'h100);
        check_eq("load_no_write", mem_we, 0);
        exp_ptr = 64'h100;
        do_instr(4'h3, 4'h0, 4'h5, 4'h2, 64'h0123456789ABCDEF, 0, 0, 0);
        check_eq("irmovq_final_ptr", wr_ptr, 64'h10A);

        do_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 0, 0, 0);
        do_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 0, 0, 0);
        do_instr(4'h9, 4'h0, 4'h0, 4'h0, 64'h0, 0, 0, 0);
        check_eq("b2b_ptr", wr_ptr, 64'h10D);

        do_instr(4'h8, 4'h0, 4'h0, 4'h0, 64'h40, 1, 64'h0, 0);
        do_instr(4'hA, 4'h0, 4'h3, 4'h7, 64'h0, 0, 0, 0);
        check_eq("push_ptr", wr_ptr, 64'hB);

        do_instr(4'hC, 4'h0, 4'h1, 4'h2, 64'h55, 0, 0, 0);
        check_eq("invalid_ptr", wr_ptr, 64'hB);
        do_instr(4'h6, 4'h5, 4'h1, 4'h2, 64'h0, 0, 0, 0);

        do_instr(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        check_eq("wrap_ptr", wr_ptr, 64'h0);

        do_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'hDEAD_BEEF_0BAD_F00D, 1, 64'h200, 3);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] ric;
            ric = 4'($urandom);
            do_instr(ric, 4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                     {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                     {$urandom, $urandom}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
